// File: rtl/switch_input_port.sv
// Memory-mapped input port for the two board sliding switches: synchronizes,
// debounces and reports switch levels plus sticky W1C edge events on the dmem bus.
module switch_input_port #(
  parameter logic [15:0] BASE_ADDR       = 16'hFFF0,
  parameter int          DEBOUNCE_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_sw0,
  input  logic        io_sw1,
  input  logic [15:0] dmemaddr,
  input  logic [15:0] dmemwdata,
  input  logic        dmemwrite,
  input  logic        dmemread,
  output logic [15:0] rdata,
  output logic        sel,
  output logic [1:0]  sw_level,
  output logic        event_pending
);

  localparam int              CNT_W      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0]     EVENT_ADDR = BASE_ADDR + 16'd2;

  logic [1:0]            raw;
  logic [1:0]            s1;
  logic [1:0]            s2;
  logic [1:0]            db;
  logic [1:0]            db_next;
  logic [1:0][CNT_W-1:0] cnt;
  logic [1:0][CNT_W-1:0] cnt_next;
  logic [3:0]            events;      // {fall1, fall0, rise1, rise0}
  logic [3:0]            events_next;
  logic [3:0]            ev_set;
  logic [3:0]            ev_clr;
  logic                  hit_data;
  logic                  hit_event;
  logic                  unused_wdata;

  assign raw = {io_sw1, io_sw0};

  // Two-flop synchronizer; the raw pins are never looked at past s1.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1 <= 2'b00;
      s2 <= 2'b00;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Each switch must disagree with its debounced level for DEBOUNCE_CYCLES
  // consecutive cycles before the level follows; one agreeing cycle restarts it.
  always_comb begin
    db_next  = db;
    cnt_next = '0;
    ev_set   = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      if (s2[i] != db[i]) begin
        if (cnt[i] == CNT_MAX) begin
          db_next[i] = s2[i];
          if (s2[i]) ev_set[i] = 1'b1;
          else       ev_set[i + 2] = 1'b1;
        end else begin
          cnt_next[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  // Bus semantics: single-cycle, no wait states. A load (dmemread) sees rdata
  // combinationally in the same cycle; a store (dmemwrite) commits at the edge.
  assign hit_data  = (dmemaddr == BASE_ADDR);
  assign hit_event = (dmemaddr == EVENT_ADDR);
  assign sel       = hit_data | hit_event;

  // Clear is applied before set so an event landing on a W1C edge survives.
  assign ev_clr      = (dmemwrite && hit_event) ? dmemwdata[3:0] : 4'b0000;
  assign events_next = (events & ~ev_clr) | ev_set;

  always_ff @(posedge clock) begin
    if (reset) begin
      db     <= 2'b00;
      cnt    <= '0;
      events <= 4'b0000;
    end else begin
      db     <= db_next;
      cnt    <= cnt_next;
      events <= events_next;
    end
  end

  always_comb begin
    rdata = 16'h0000;
    if (dmemread) begin
      if (hit_data)       rdata = {14'b0, db};
      else if (hit_event) rdata = {12'b0, events};
    end
  end

  assign sw_level      = db;
  assign event_pending = |events;

  // Upper write-data bits carry nothing for this port.
  assign unused_wdata = ^dmemwdata[15:4];

endmodule
